axi_rd_master: RTL and testbench

AXI_RD_MASTER -- requirements
Module: axi_rd_master

---
 rtl/axi_rd_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_rd_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_master.sv
// axi_rd_master
//   Turns client burst requests into AXI4 read-address transactions and
//   forwards the returning read beats to the client, keeping an in-order
//   record of issued bursts so that beat counting, last-beat marking and
//   protocol checking can be done locally.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready          client burst request handshake
//   cmd_addr/len/id          start address, beats-1, transaction ID
//   m_axi_ar*                AXI read-address channel (master side)
//   m_axi_r*                 AXI read-data channel (master side)
//   rsp_valid/ready          client returned-beat handshake
//   rsp_data/id/last/resp    returned beat payload
//   outstanding              bursts accepted but not yet fully returned
//   err_last/err_id/err_unexp  sticky protocol-error flags
module axi_rd_master #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 16,
  parameter int ID_WIDTH            = 8,
  parameter int LOG_MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // client request
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [7:0]                   cmd_len,
  input  logic [ID_WIDTH-1:0]          cmd_id,
  // AXI AR channel
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arlock,
  output logic [3:0]                   m_axi_arcache,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  // AXI R channel
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  // client response
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic                         rsp_last,
  output logic [1:0]                   rsp_resp,
  // status
  output logic [LOG_MAX_OUTSTANDING:0] outstanding,
  output logic                         err_last,
  output logic                         err_id,
  output logic                         err_unexp
);

  localparam int DEPTH = 1 << LOG_MAX_OUTSTANDING;
  localparam int PTR_W = LOG_MAX_OUTSTANDING;
  localparam int CNT_W = LOG_MAX_OUTSTANDING + 1;

  typedef enum logic { AR_IDLE, AR_BUSY } arState_t;

  arState_t                arState_q;
  logic                    arValid_q;
  logic [ADDR_WIDTH-1:0]   arAddr_q;
  logic [7:0]              arLen_q;
  logic [ID_WIDTH-1:0]     arId_q;

  logic [7:0]              lenMem_q [DEPTH];
  logic [ID_WIDTH-1:0]     idMem_q  [DEPTH];
  logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              beatCnt_q, beatCnt_d;
  logic                    errLast_q, errId_q, errUnexp_q;

  logic fifoEmpty, fifoFull, push, pop, rHs, lastBeat;
  logic [7:0]          headLen;
  logic [ID_WIDTH-1:0] headId;

  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  assign m_axi_arvalid = arValid_q;
  assign m_axi_araddr  = arAddr_q;
  assign m_axi_arlen   = arLen_q;
  assign m_axi_arid    = arId_q;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(DEPTH));
  assign headLen   = lenMem_q[rdPtr_q];
  assign headId    = idMem_q[rdPtr_q];

  // A new request may be taken while the AR slot is free or is being
  // emptied this very cycle, and only if there is room to track it.
  assign cmd_ready = ((arState_q == AR_IDLE) || m_axi_arready) && !fifoFull;
  assign push      = cmd_valid && cmd_ready;

  // With nothing outstanding, stray beats are swallowed (rready high) and
  // never shown to the client.
  assign rsp_valid    = m_axi_rvalid && !fifoEmpty;
  assign m_axi_rready = rsp_ready || fifoEmpty;
  assign rHs          = m_axi_rvalid && rsp_ready && !fifoEmpty;
  assign lastBeat     = !fifoEmpty && (beatCnt_q == headLen);
  assign pop          = rHs && lastBeat;

  assign rsp_data    = m_axi_rdata;
  assign rsp_id      = m_axi_rid;
  assign rsp_resp    = m_axi_rresp;
  assign rsp_last    = lastBeat;
  assign outstanding = count_q;
  assign err_last    = errLast_q;
  assign err_id      = errId_q;
  assign err_unexp   = errUnexp_q;

  // AR channel FSM: payload loads on every accepted request, including the
  // back-to-back case where the previous address is accepted the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arState_q <= AR_IDLE;
      arValid_q <= 1'b0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arId_q    <= '0;
    end else begin
      case (arState_q)
        AR_IDLE: begin
          if (push) begin
            arState_q <= AR_BUSY;
            arValid_q <= 1'b1;
            arAddr_q  <= cmd_addr;
            arLen_q   <= cmd_len;
            arId_q    <= cmd_id;
          end
        end
        AR_BUSY: begin
          if (m_axi_arready) begin
            if (push) begin
              arAddr_q <= cmd_addr;
              arLen_q  <= cmd_len;
              arId_q   <= cmd_id;
            end else begin
              arState_q <= AR_IDLE;
              arValid_q <= 1'b0;
            end
          end
        end
        default: begin
          arState_q <= AR_IDLE;
          arValid_q <= 1'b0;
        end
      endcase
    end
  end

  // Tracking storage needs no reset: entries are only read while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      lenMem_q[wrPtr_q] <= cmd_len;
      idMem_q[wrPtr_q]  <= cmd_id;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // The burst always ends on the counted length, whatever rlast says.
  always_comb begin
    beatCnt_d = beatCnt_q;
    if (pop)      beatCnt_d = 8'd0;
    else if (rHs) beatCnt_d = beatCnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      beatCnt_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q   <= count_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errLast_q  <= 1'b0;
      errId_q    <= 1'b0;
      errUnexp_q <= 1'b0;
    end else begin
      if (rHs && (m_axi_rlast != lastBeat)) errLast_q  <= 1'b1;
      if (rHs && (m_axi_rid != headId))     errId_q    <= 1'b1;
      if (m_axi_rvalid && fifoEmpty)        errUnexp_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
// tb_axi_rd_master
//   Self-checking bench for axi_rd_master: a table of single-burst vectors,
//   hand-written multi-cycle corner sequences, and a randomized run checked
//   against a queue-based model of the outstanding bursts.
module tb_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len, cmd_id;
  logic [7:0]  m_axi_arid, m_axi_arlen;
  logic [15:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_arvalid, m_axi_arready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [2:0]  outstanding;
  logic        err_last, err_id, err_unexp;

  int testsRun = 0;
  int testsFailed = 0;

  axi_rd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .rsp_resp(rsp_resp),
    .outstanding(outstanding), .err_last(err_last), .err_id(err_id), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    int          rlastBeat;
    logic        badId;
    logic        expErrLast;
    logic        expErrId;
  } vec_t;

  typedef struct {
    logic [7:0] len;
    logic [7:0] id;
  } burst_t;

  vec_t   vectors [5];
  burst_t modelQ [$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3
  // units later, well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    m_axi_arready = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rvalid = 0; rsp_ready = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic setCmd(input logic [15:0] a, input logic [7:0] l, input logic [7:0] i);
    cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_id = i;
  endtask

  task automatic setBeat(input logic [7:0] i, input logic last);
    m_axi_rvalid = 1; m_axi_rid = i; m_axi_rlast = last;
    m_axi_rdata = $urandom; m_axi_rresp = 2'($urandom_range(0, 3));
  endtask

  // One complete burst from a vector: request, address handshake, beats.
  task automatic applyStimulus(input vec_t v);
    doReset();
    m_axi_arready = 1; rsp_ready = 1;
    setCmd(v.addr, v.len, v.id);
    #3 checkOutput("vec cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    #3;
    checkOutput("vec arvalid", m_axi_arvalid, 1);
    checkOutput("vec araddr", m_axi_araddr, v.addr);
    checkOutput("vec arlen", m_axi_arlen, v.len);
    checkOutput("vec arid", m_axi_arid, v.id);
    checkOutput("vec outstanding1", outstanding, 1);
    step();
    #3 checkOutput("vec arvalid drop", m_axi_arvalid, 0);
    for (int b = 0; b <= int'(v.len); b++) begin
      setBeat(v.badId ? (v.id ^ 8'h01) : v.id, b == v.rlastBeat);
      #3;
      checkOutput("vec rsp_valid", rsp_valid, 1);
      checkOutput("vec rsp_data", rsp_data, m_axi_rdata);
      checkOutput("vec rsp_resp", rsp_resp, m_axi_rresp);
      checkOutput("vec rsp_last", rsp_last, b == int'(v.len));
      step();
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #3;
    checkOutput("vec outstanding0", outstanding, 0);
    checkOutput("vec err_last", err_last, v.expErrLast);
    checkOutput("vec err_id", err_id, v.expErrId);
    checkOutput("vec err_unexp", err_unexp, 0);
    step();
  endtask

  initial begin
    vectors[0] = '{16'h0100, 8'd3, 8'h05, 3,  1'b0, 1'b0, 1'b0};
    vectors[1] = '{16'h0000, 8'd0, 8'h11, 0,  1'b0, 1'b0, 1'b0};
    vectors[2] = '{16'h1234, 8'd1, 8'h22, 0,  1'b0, 1'b1, 1'b0};
    vectors[3] = '{16'hFFFC, 8'd2, 8'h7F, 2,  1'b1, 1'b0, 1'b1};
    vectors[4] = '{16'hABCD, 8'd7, 8'hFF, 99, 1'b0, 1'b1, 1'b0};

    // Reset values, including the constant AR fields.
    clearInputs();
    rst = 0;
    @(posedge clk); #4;
    checkOutput("rst arvalid", m_axi_arvalid, 0);
    checkOutput("rst araddr", m_axi_araddr, 0);
    checkOutput("rst arlen", m_axi_arlen, 0);
    checkOutput("rst arid", m_axi_arid, 0);
    checkOutput("rst outstanding", outstanding, 0);
    checkOutput("rst errors", {err_last, err_id, err_unexp}, 0);
    checkOutput("rst cmd_ready", cmd_ready, 1);
    checkOutput("arsize", m_axi_arsize, 3'd2);
    checkOutput("arburst", m_axi_arburst, 2'b01);
    checkOutput("arcache", m_axi_arcache, 4'b0011);
    checkOutput("arlock/arprot", {m_axi_arlock, m_axi_arprot}, 0);

    for (int v = 0; v < 5; v++) applyStimulus(vectors[v]);

    // Address stall: payload must hold while arready is low, then a
    // back-to-back request is taken on the accepting cycle.
    doReset();
    setCmd(16'h55AA, 8'd4, 8'h03);
    step();
    setCmd(16'h6000, 8'd0, 8'h09);
    for (int c = 0; c < 5; c++) begin
      #3;
      checkOutput("stall arvalid", m_axi_arvalid, 1);
      checkOutput("stall araddr", m_axi_araddr, 16'h55AA);
      checkOutput("stall arid", m_axi_arid, 8'h03);
      checkOutput("stall cmd_ready", cmd_ready, 0);
      step();
    end
    m_axi_arready = 1;
    #3 checkOutput("stall release cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    #3;
    checkOutput("b2b arvalid", m_axi_arvalid, 1);
    checkOutput("b2b araddr", m_axi_araddr, 16'h6000);
    checkOutput("b2b outstanding", outstanding, 2);
    step();
    #3 checkOutput("b2b arvalid drop", m_axi_arvalid, 0);

    // Fill the tracking FIFO with R stalled, then free one slot.
    doReset();
    m_axi_arready = 1;
    for (int k = 0; k < 4; k++) begin
      setCmd(16'h1000 + 16'(k * 16), 8'd1, 8'(k));
      #3 checkOutput("fill cmd_ready", cmd_ready, 1);
      step();
    end
    cmd_valid = 0;
    #3;
    checkOutput("full outstanding", outstanding, 4);
    checkOutput("full cmd_ready", cmd_ready, 0);
    step();
    rsp_ready = 1;
    for (int b = 0; b < 2; b++) begin
      setBeat(8'd0, b == 1);
      #3 checkOutput("drain rsp_last", rsp_last, b == 1);
      step();
    end
    m_axi_rvalid = 0;
    #3;
    checkOutput("drain outstanding", outstanding, 3);
    checkOutput("drain cmd_ready", cmd_ready, 1);
    step();

    // Early rlast: error is sticky and the following burst is still tracked.
    doReset();
    m_axi_arready = 1; rsp_ready = 1;
    for (int n = 0; n < 2; n++) begin
      setCmd(16'h2000, 8'd1, 8'h21 + 8'(n));
      step();
      cmd_valid = 0;
      step();
      for (int b = 0; b < 2; b++) begin
        setBeat(8'h21 + 8'(n), (n == 0) ? (b == 0) : (b == 1));
        #3 checkOutput("rlast rsp_last", rsp_last, b == 1);
        step();
      end
      m_axi_rvalid = 0;
      #3;
      checkOutput("rlast err_last", err_last, 1);
      checkOutput("rlast outstanding", outstanding, 0);
      checkOutput("rlast err_id", err_id, 0);
      step();
    end

    // Unexpected beat with nothing outstanding.
    doReset();
    setBeat(8'h09, 1'b1);
    #3;
    checkOutput("unexp rsp_valid", rsp_valid, 0);
    checkOutput("unexp rready", m_axi_rready, 1);
    step();
    m_axi_rvalid = 0;
    #3;
    checkOutput("unexp err_unexp", err_unexp, 1);
    checkOutput("unexp outstanding", outstanding, 0);
    step();

    // Reset in the middle of a burst.
    doReset();
    m_axi_arready = 1; rsp_ready = 1;
    setCmd(16'h3000, 8'd3, 8'h04);
    step();
    cmd_valid = 0;
    step();
    setBeat(8'h04, 1'b0);
    step();
    setBeat(8'h04, 1'b0);
    #2 rst = 0;
    #1;
    checkOutput("midrst outstanding", outstanding, 0);
    checkOutput("midrst arvalid", m_axi_arvalid, 0);
    checkOutput("midrst araddr", m_axi_araddr, 0);
    checkOutput("midrst rsp_valid", rsp_valid, 0);
    checkOutput("midrst errors", {err_last, err_id, err_unexp}, 0);
    step();
    rst = 1;
    #3;
    checkOutput("postrst rsp_valid", rsp_valid, 0);
    checkOutput("postrst rready", m_axi_rready, 1);
    step();
    m_axi_rvalid = 0;
    #3 checkOutput("postrst err_unexp", err_unexp, 1);
    setCmd(16'h4000, 8'd0, 8'h33);
    #0 checkOutput("postrst cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    #3;
    checkOutput("postrst arvalid", m_axi_arvalid, 1);
    checkOutput("postrst araddr", m_axi_araddr, 16'h4000);
    checkOutput("postrst outstanding1", outstanding, 1);
    step();
    setBeat(8'h33, 1'b1);
    #3;
    checkOutput("postrst beat valid", rsp_valid, 1);
    checkOutput("postrst beat last", rsp_last, 1);
    step();
    m_axi_rvalid = 0;
    #3;
    checkOutput("postrst outstanding0", outstanding, 0);
    checkOutput("postrst err_last", err_last, 0);
    step();

    // Randomized traffic against a queue model of outstanding bursts.
    begin
      logic        arPend, expCmdReady, cmdFire, rFire;
      logic [15:0] mAddr;
      logic [7:0]  mId;
      int          beatIdx;
      doReset();
      modelQ.delete();
      arPend = 0; mAddr = 0; mId = 0; beatIdx = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        m_axi_arready = 1'($urandom_range(0, 1));
        rsp_ready     = 1'($urandom_range(0, 1));
        cmd_valid     = 1'($urandom_range(0, 1));
        cmd_addr      = 16'($urandom);
        cmd_len       = 8'($urandom_range(0, 3));
        cmd_id        = 8'($urandom);
        m_axi_rdata   = $urandom;
        if (modelQ.size() > 0) begin
          m_axi_rvalid = 1'($urandom_range(0, 1));
          m_axi_rid    = modelQ[0].id;
          m_axi_rlast  = (beatIdx == int'(modelQ[0].len));
        end else begin
          m_axi_rvalid = 0;
          m_axi_rid    = 8'($urandom);
          m_axi_rlast  = 0;
        end
        expCmdReady = (!arPend || m_axi_arready) && (modelQ.size() < 4);
        #3;
        checkOutput("rnd cmd_ready", cmd_ready, expCmdReady);
        checkOutput("rnd outstanding", outstanding, modelQ.size());
        checkOutput("rnd arvalid", m_axi_arvalid, arPend);
        if (arPend) begin
          checkOutput("rnd araddr", m_axi_araddr, mAddr);
          checkOutput("rnd arid", m_axi_arid, mId);
        end
        checkOutput("rnd rsp_valid", rsp_valid, m_axi_rvalid && (modelQ.size() > 0));
        checkOutput("rnd rready", m_axi_rready, rsp_ready || (modelQ.size() == 0));
        if (modelQ.size() > 0)
          checkOutput("rnd rsp_last", rsp_last, beatIdx == int'(modelQ[0].len));
        cmdFire = cmd_valid && expCmdReady;
        rFire   = m_axi_rvalid && rsp_ready && (modelQ.size() > 0);
        if (rFire) begin
          if (beatIdx == int'(modelQ[0].len)) begin
            void'(modelQ.pop_front());
            beatIdx = 0;
          end else begin
            beatIdx++;
          end
        end
        if (cmdFire) begin
          modelQ.push_back('{cmd_len, cmd_id});
          arPend = 1; mAddr = cmd_addr; mId = cmd_id;
        end else if (arPend && m_axi_arready) begin
          arPend = 0;
        end
        step();
      end
      clearInputs();
      #3 checkOutput("rnd errors", {err_last, err_id, err_unexp}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
